gpio_arbiter: RTL and testbench

- Two-requester controller in front of the GPIO register block: shares its register port (select, write enable, 32-bit write data, 32-bit read data) between master 0 (CPU load/store path) and master 1 (debug/DMA).
- Adds atomic bit operations (set, clear, toggle) via an internal read-modify-write sequence, so neither master can corrupt the other's bits in the same register.
- Sits between the bus decoder and the GPIO block; it is the only driver of the GPIO register port.

---
 rtl/gpio_arbiter.sv | 155 +++++++++++++++
 tb/tb_gpio_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_arbiter
// Description : Two-master arbiter for the GPIO register port. Provides
//               atomic set/clear/toggle through an internal read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [2:0]  m0_op,
    input  logic [2:0]  m0_sel,
    input  logic [7:0]  m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic [2:0]  m1_op,
    input  logic [2:0]  m1_sel,
    input  logic [7:0]  m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [7:0]  m1_rdata,
    output logic [2:0]  gpio_sel,
    output logic        gpio_we,
    output logic [31:0] gpio_di,
    input  logic [31:0] gpio_do
);

    localparam logic [2:0] c_OP_READ   = 3'd0;
    localparam logic [2:0] c_OP_WRITE  = 3'd1;
    localparam logic [2:0] c_OP_SET    = 3'd2;
    localparam logic [2:0] c_OP_CLEAR  = 3'd3;
    localparam logic [2:0] c_OP_TOGGLE = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic        r_err;
    logic [2:0]  r_op;
    logic [2:0]  r_gpio_sel;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rd_q;

    logic        w_any_req;
    logic        w_gnt;
    logic [2:0]  w_op;
    logic [2:0]  w_sel;
    logic [7:0]  w_wdata;
    logic        w_reject;
    logic [7:0]  w_wr_val;
    logic        w_done;
    logic        w_unused;

    // Selects 010 and 101 are live input pins; 110 and 111 are unmapped.
    function automatic logic f_reject(input logic [2:0] op, input logic [2:0] sel);
        logic ro;
        ro = (sel == 3'd2) || (sel == 3'd5) || (sel == 3'd6) || (sel == 3'd7);
        return (op > c_OP_TOGGLE) || ((op != c_OP_READ) && ro);
    endfunction

    always_comb begin
        w_any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            w_gnt = PRIO_FIXED ? 1'b0 : ~r_last;
        end else begin
            w_gnt = m1_req;
        end
        w_op     = w_gnt ? m1_op    : m0_op;
        w_sel    = w_gnt ? m1_sel   : m0_sel;
        w_wdata  = w_gnt ? m1_wdata : m0_wdata;
        w_reject = f_reject(w_op, w_sel);
    end

    always_comb begin
        w_wr_val = r_wdata;
        case (r_op)
            c_OP_SET:    w_wr_val = r_rd_q | r_wdata;
            c_OP_CLEAR:  w_wr_val = r_rd_q & ~r_wdata;
            c_OP_TOGGLE: w_wr_val = r_rd_q ^ r_wdata;
            default:     w_wr_val = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_err      <= 1'b0;
            r_op       <= c_OP_READ;
            r_gpio_sel <= 3'd0;
            r_wdata    <= 8'h00;
            r_rd_q     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_gnt;
                        r_last  <= w_gnt;
                        r_op    <= w_op;
                        r_wdata <= w_wdata;
                        if (w_reject) begin
                            r_err   <= 1'b1;
                            r_rd_q  <= 8'h00;
                            r_state <= S_DONE;
                        end else begin
                            r_err      <= 1'b0;
                            r_gpio_sel <= w_sel;
                            r_state    <= (w_op == c_OP_WRITE) ? S_WR : S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_rd_q  <= gpio_do[7:0];
                    r_state <= (r_op == c_OP_READ) ? S_DONE : S_WR;
                end
                S_WR: begin
                    r_rd_q  <= w_wr_val;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, so no req-to-output path.
    assign w_done   = (r_state == S_DONE);
    assign gpio_sel = r_gpio_sel;
    assign gpio_we  = (r_state == S_WR);
    assign gpio_di  = {24'h000000, gpio_we ? w_wr_val : 8'h00};

    assign m0_ack   = w_done & ~r_owner;
    assign m0_err   = m0_ack & r_err;
    assign m0_rdata = m0_ack ? r_rd_q : 8'h00;
    assign m1_ack   = w_done & r_owner;
    assign m1_err   = m1_ack & r_err;
    assign m1_rdata = m1_ack ? r_rd_q : 8'h00;

    assign w_unused = ^gpio_do[31:8];

endmodule
`default_nettype wire

// File: tb/tb_gpio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_arbiter
// Description : Directed bench for gpio_arbiter with an ack scoreboard and a
//               behavioural GPIO register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_arbiter;

    localparam logic [2:0] c_RD  = 3'd0;
    localparam logic [2:0] c_WR  = 3'd1;
    localparam logic [2:0] c_SET = 3'd2;
    localparam logic [2:0] c_CLR = 3'd3;
    localparam logic [2:0] c_TGL = 3'd4;

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req, f_m0_req, f_m1_req;
    logic [2:0]  m0_op, m0_sel, m1_op, m1_sel;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [2:0]  gpio_sel;
    logic        gpio_we;
    logic [31:0] gpio_di, gpio_do;
    logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
    logic [7:0]  f_m0_rdata, f_m1_rdata;
    logic [2:0]  f_gpio_sel;
    logic        f_gpio_we;
    logic [31:0] f_gpio_di, f_gpio_do;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       m;
        logic [7:0] rd;
        logic       err;
    } exp_t;
    exp_t sb_q[$];

    // GPIO model: contents survive reset, writes during reset are lost.
    logic [7:0] gregs [8] = '{default: 8'h00};
    logic [7:0] pins_a = 8'h00;
    logic [7:0] w_gdo8;

    always_comb begin
        w_gdo8 = gregs[gpio_sel];
        if (gpio_sel == 3'd2 || gpio_sel == 3'd5) w_gdo8 = pins_a;
    end
    assign gpio_do   = {24'hABCDEF, w_gdo8};
    assign f_gpio_do = 32'h00000000;

    always @(posedge clk) begin
        if (gpio_we && !reset) gregs[gpio_sel] <= gpio_di[7:0];
    end

    gpio_arbiter #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_op(m0_op), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_op(m1_op), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .gpio_sel(gpio_sel), .gpio_we(gpio_we), .gpio_di(gpio_di), .gpio_do(gpio_do)
    );

    gpio_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .reset(reset),
        .m0_req(f_m0_req), .m0_op(m0_op), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_ack(f_m0_ack), .m0_err(f_m0_err), .m0_rdata(f_m0_rdata),
        .m1_req(f_m1_req), .m1_op(m1_op), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_ack(f_m1_ack), .m1_err(f_m1_err), .m1_rdata(f_m1_rdata),
        .gpio_sel(f_gpio_sel), .gpio_we(f_gpio_we), .gpio_di(f_gpio_di), .gpio_do(f_gpio_do)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input bit m, input logic req, input logic [2:0] op,
                         input logic [2:0] sel, input logic [7:0] wd);
        if (m) begin
            m1_req = req; m1_op = op; m1_sel = sel; m1_wdata = wd;
        end else begin
            m0_req = req; m0_op = op; m0_sel = sel; m0_wdata = wd;
        end
    endtask

    // Called at a falling edge with the DUT idle; returns with the DUT idle again.
    task automatic txn(input string tag, input bit m, input logic [2:0] op,
                       input logic [2:0] sel, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input bit exp_err, input int exp_lat,
                       input int exp_we, input logic [7:0] exp_di);
        int lat = 0;
        int we_n = 0;
        bit got = 0;
        logic [7:0] di_seen = 8'h00;
        logic [2:0] sel_seen = 3'd0;
        drive(m, 1'b1, op, sel, wd);
        sb_q.push_back('{m: m, rd: exp_rd, err: exp_err});
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (gpio_we) begin
                we_n++;
                di_seen  = gpio_di[7:0];
                sel_seen = gpio_sel;
                chk({tag, "_di_upper"}, {8'h00, gpio_di[31:8]}, 32'h0);
            end
            if (m ? m1_ack : m0_ack) got = 1;
            // post-grant input changes must be ignored
            else drive(m, 1'b1, op, sel ^ 3'd1, ~wd);
        end
        drive(m, 1'b0, 3'd0, 3'd0, 8'h00);
        chk({tag, "_acked"}, {31'd0, got}, 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_we_cycles"}, we_n, exp_we);
        if (exp_we > 0) begin
            chk({tag, "_di"}, {24'h0, di_seen}, {24'h0, exp_di});
            chk({tag, "_wsel"}, {29'h0, sel_seen}, {29'h0, sel});
        end
        @(negedge clk);
    endtask

    // Both masters of one instance request together; checks who is served first.
    task automatic contend(input string tag, input bit fx, input bit exp_first);
        int n = 0;
        bit d0 = 0, d1 = 0, have_first = 0, first = 0;
        m0_op = c_WR; m0_sel = 3'd1; m0_wdata = 8'h11;
        m1_op = c_WR; m1_sel = 3'd3; m1_wdata = 8'h22;
        if (fx) begin
            f_m0_req = 1'b1; f_m1_req = 1'b1;
        end else begin
            m0_req = 1'b1; m1_req = 1'b1;
            sb_q.push_back('{m: exp_first,  rd: exp_first ? 8'h22 : 8'h11, err: 1'b0});
            sb_q.push_back('{m: !exp_first, rd: exp_first ? 8'h11 : 8'h22, err: 1'b0});
        end
        while (!(d0 && d1) && n < 30) begin
            @(negedge clk);
            n++;
            if ((fx ? f_m0_ack : m0_ack) && !d0) begin
                d0 = 1;
                if (!have_first) begin have_first = 1; first = 0; end
                if (fx) f_m0_req = 1'b0; else m0_req = 1'b0;
            end
            if ((fx ? f_m1_ack : m1_ack) && !d1) begin
                d1 = 1;
                if (!have_first) begin have_first = 1; first = 1; end
                if (fx) f_m1_req = 1'b0; else m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0; f_m0_req = 1'b0; f_m1_req = 1'b0;
        chk({tag, "_both_done"}, {30'd0, d0, d1}, 32'd3);
        chk({tag, "_first"}, {31'd0, first}, {31'd0, exp_first});
        @(negedge clk);
    endtask

    task automatic fx_single_m0();
        int n = 0;
        bit got = 0;
        m0_op = c_WR; m0_sel = 3'd4; m0_wdata = 8'h44;
        f_m0_req = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (f_m0_ack) got = 1;
        end
        f_m0_req = 1'b0;
        chk("fx_single_ack", {31'd0, got}, 32'd1);
        @(negedge clk);
    endtask

    // Scoreboard: every ack of the main instance must match the next expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && (m0_ack || m1_ack)) begin
            chk("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_master", {31'd0, m1_ack}, {31'd0, e.m});
                chk("sb_rdata", {24'd0, e.m ? m1_rdata : m0_rdata}, {24'd0, e.rd});
                chk("sb_err", {31'd0, e.m ? m1_err : m0_err}, {31'd0, e.err});
                chk("sb_other_quiet",
                    {22'd0, e.m ? {m0_ack, m0_err, m0_rdata} : {m1_ack, m1_err, m1_rdata}}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation timed out");
    end

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; f_m0_req = 1'b0; f_m1_req = 1'b0;
        m0_op = 3'd0; m0_sel = 3'd0; m0_wdata = 8'h00;
        m1_op = 3'd0; m1_sel = 3'd0; m1_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_m0_out", {22'd0, m0_ack, m0_err, m0_rdata}, 32'd0);
        chk("rst_m1_out", {22'd0, m1_ack, m1_err, m1_rdata}, 32'd0);
        chk("rst_gpio_ctl", {28'd0, gpio_sel, gpio_we}, 32'd0);
        chk("rst_gpio_di", gpio_di, 32'd0);
        chk("rst_fx_out", {14'd0, f_m0_ack, f_m0_err, f_m0_rdata, f_m1_ack, f_m1_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Round robin: fresh pointer prefers m0; after an m0-only grant, m1 wins.
        contend("rr_a", 1'b0, 1'b0);
        txn("m0_wr_sel4", 1'b0, c_WR, 3'd4, 8'h44, 8'h44, 1'b0, 2, 1, 8'h44);
        contend("rr_b", 1'b0, 1'b1);

        // Fixed priority keeps m0 ahead even when round robin would pick m1.
        contend("fx_a", 1'b1, 1'b0);
        fx_single_m0();
        contend("fx_b", 1'b1, 1'b0);

        txn("m0_wr_a5",  1'b0, c_WR,  3'd0, 8'hA5, 8'hA5, 1'b0, 2, 1, 8'hA5);
        txn("m1_set",    1'b1, c_SET, 3'd0, 8'h0A, 8'hAF, 1'b0, 3, 1, 8'hAF);
        txn("m1_clr",    1'b1, c_CLR, 3'd0, 8'h81, 8'h2E, 1'b0, 3, 1, 8'h2E);
        txn("m1_tgl",    1'b1, c_TGL, 3'd0, 8'hFF, 8'hD1, 1'b0, 3, 1, 8'hD1);
        chk("model_sel0", {24'd0, gregs[0]}, 32'hD1);

        txn("m0_wr_ro",  1'b0, c_WR,  3'd2, 8'h55, 8'h00, 1'b1, 1, 0, 8'h00);
        txn("m0_ill_op", 1'b0, 3'd7,  3'd0, 8'h55, 8'h00, 1'b1, 1, 0, 8'h00);
        txn("m1_set_in", 1'b1, c_SET, 3'd5, 8'h01, 8'h00, 1'b1, 1, 0, 8'h00);
        txn("m0_tgl_un", 1'b0, c_TGL, 3'd7, 8'h01, 8'h00, 1'b1, 1, 0, 8'h00);

        pins_a = 8'h3C;
        txn("m1_rd_pins", 1'b1, c_RD, 3'd2, 8'h00, 8'h3C, 1'b0, 2, 0, 8'h00);
        txn("m0_rd_sel1", 1'b0, c_RD, 3'd1, 8'h00, 8'h11, 1'b0, 2, 0, 8'h00);
        txn("m1_rd_sel3", 1'b1, c_RD, 3'd3, 8'h00, 8'h22, 1'b0, 2, 0, 8'h00);

        // Toggle aborted by reset landing in its write cycle.
        drive(1'b0, 1'b1, c_TGL, 3'd0, 8'h0F);
        @(negedge clk);
        chk("abort_rd_we", {31'd0, gpio_we}, 32'd0);
        @(negedge clk);
        chk("abort_wr_we", {31'd0, gpio_we}, 32'd1);
        chk("abort_wr_di", gpio_di, 32'h000000DE);
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_we_still", {31'd0, gpio_we}, 32'd0);
        chk("abort_m0_out", {22'd0, m0_ack, m0_err, m0_rdata}, 32'd0);
        chk("abort_gpio", {gpio_di[28:0], gpio_sel}, 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_model_kept", {24'd0, gregs[0]}, 32'hD1);
        txn("m0_rd_after", 1'b0, c_RD, 3'd0, 8'h00, 8'hD1, 1'b0, 2, 0, 8'h00);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
